// File: rtl/w_serializer.sv
// -----------------------------------------------------------------------------
// w_serializer
//
// Parallel-to-serial source for the sequence-detector pair. Words arrive on a
// valid/ready handshake and leave one bit per clock on `w`. A one-word hold
// register lets a second word wait while the current one is shifting, so
// back-to-back words come out with no gap between them. When nothing is being
// shifted, `w` sits at IDLE_LEVEL.
//
// Parameters:
//   WIDTH       bits per word (2..32)
//   IDLE_LEVEL  level driven on `w` when no data bit is present
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   upstream offers a word
//   in_data    word to serialize (sampled only on the accept edge)
//   in_ready   block can take a word this cycle
//   w          serial data bit
//   w_valid    `w` carries a data bit this cycle
//   word_done  current `w` bit is the last bit of its word
//   busy       shifter active or hold register occupied
//
// Configuration macro:
//   W_SERIALIZER_LSB_FIRST_EN  defined: LSB first (shift right)
//                              undefined: MSB first (shift left, default)
// -----------------------------------------------------------------------------
module w_serializer #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             w,
    output logic             w_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sr_reg;
    logic [WIDTH-1:0] hr_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             active_reg;
    logic             hold_full_reg;

    logic [WIDTH-1:0] sr_next_shift;
    logic             out_bit;
    logic             last_bit;
    logic             shifter_free;
    logic             accept;

`ifdef W_SERIALIZER_LSB_FIRST_EN
    assign out_bit       = sr_reg[0];
    assign sr_next_shift = {1'b0, sr_reg[WIDTH-1:1]};
`else
    assign out_bit       = sr_reg[WIDTH-1];
    assign sr_next_shift = {sr_reg[WIDTH-2:0], 1'b0};
`endif

    assign last_bit     = active_reg && (cnt_reg == LAST_CNT);
    // The shifter can take a new word on the same edge its last bit finishes,
    // which is what keeps streaming gapless.
    assign shifter_free = !active_reg || last_bit;

    // rst gates in_ready directly so it is low the instant reset asserts.
    assign in_ready = ~rst & ~hold_full_reg;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_reg        <= '0;
            hr_reg        <= '0;
            cnt_reg       <= '0;
            active_reg    <= 1'b0;
            hold_full_reg <= 1'b0;
        end else if (shifter_free && hold_full_reg) begin
            // Held word moves into the shifter; in_ready is low, so no accept
            // can coincide with this.
            sr_reg        <= hr_reg;
            hold_full_reg <= 1'b0;
            active_reg    <= 1'b1;
            cnt_reg       <= '0;
        end else if (shifter_free && accept) begin
            sr_reg     <= in_data;
            active_reg <= 1'b1;
            cnt_reg    <= '0;
        end else begin
            if (accept) begin
                hr_reg        <= in_data;
                hold_full_reg <= 1'b1;
            end
            if (active_reg && !shifter_free) begin
                sr_reg  <= sr_next_shift;
                cnt_reg <= cnt_reg + 1'b1;
            end else if (shifter_free) begin
                // Reaching here with the shifter free means nothing to load.
                active_reg <= 1'b0;
            end
        end
    end

    assign w         = active_reg ? out_bit : IDLE_LEVEL;
    assign w_valid   = active_reg;
    assign word_done = last_bit;
    assign busy      = active_reg | hold_full_reg;

endmodule

// File: tb/tb_w_serializer.sv
module tb_w_serializer;

    localparam int   WIDTH = 8;
    localparam logic IDLE  = 1'b1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             w;
    logic             w_valid;
    logic             word_done;
    logic             busy;

    w_serializer #(
        .WIDTH      (WIDTH),
        .IDLE_LEVEL (IDLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .w         (w),
        .w_valid   (w_valid),
        .word_done (word_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic done;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   run_len = 0;
    int   max_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops one expected bit for every w_valid cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (w_valid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bit: got w=%0b w_valid=1, required no data bit", w);
                end else begin
                    e = exp_q.pop_front();
                    if (w !== e.b || word_done !== e.done) begin
                        errors++;
                        $display("FAIL stream @cyc %0d: got w=%0b done=%0b, required w=%0b done=%0b",
                                 cyc, w, word_done, e.b, e.done);
                    end
                end
            end else begin
                run_len = 0;
                checks++;
                if (w !== IDLE || word_done !== 1'b0) begin
                    errors++;
                    $display("FAIL idle @cyc %0d: got w=%0b done=%0b, required w=%0b done=0",
                             cyc, w, word_done, IDLE);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Push a hand-written bit sequence, seq[7] leaves first.
    task automatic push_seq(input logic [7:0] seq);
        exp_t e;
        for (int i = 7; i >= 0; i--) begin
            e.b    = seq[i];
            e.done = (i == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        logic [7:0] seq;
        for (int i = 0; i < 8; i++) begin
`ifdef W_SERIALIZER_LSB_FIRST_EN
            seq[7-i] = d[i];
`else
            seq[7-i] = d[7-i];
`endif
        end
        push_seq(seq);
    endtask

    // Offer a word until accepted; returns the cycle number of the accept edge.
    // Leaves in_valid high. Called just after a rising edge.
    task automatic send(input logic [7:0] d, output int acc_cyc);
        bit acc = 0;
        int t   = 0;
        in_valid = 1'b1;
        in_data  = d;
        acc_cyc  = -1;
        while (!acc && t < 100) begin
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (acc) begin
            acc_cyc = cyc;
            push_word(d);
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: word %02h not accepted within 100 cycles", d);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int a0, a1, a2;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset asserted mid-cycle, before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst_w", w, IDLE);
        check("rst_w_valid", w_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_word_done", word_done, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("release_in_ready", in_ready, 1);
        idle_cycles(4);

        // Single word 0xB4, hand vector.
        in_valid = 1'b1;
        in_data  = 8'hB4;
        check("single_ready", in_ready, 1);
        @(posedge clk);
        #1;
`ifdef W_SERIALIZER_LSB_FIRST_EN
        push_seq(8'b0010_1101);
`else
        push_seq(8'b1011_0100);
`endif
        in_valid = 1'b0;
        in_data  = 8'h00;
        idle_cycles(10);
        check("single_busy_end", busy, 0);
        check("single_q_empty", exp_q.size(), 0);

        // Back-to-back with in_valid held high.
        max_run = 0;
        send(8'hFF, a0);
        send(8'h00, a1);
        check("b2b_ready_low_held", in_ready, 0);
        check("b2b_busy", busy, 1);
        send(8'hA5, a2);
        check("b2b_ready_low_third", in_ready, 0);
        in_valid = 1'b0;
        check("b2b_second_accept", a1 - a0, 1);
        check("b2b_third_accept", a2 - a0, 9);
        idle_cycles(24);
        check("b2b_contiguous", max_run, 24);
        check("b2b_q_empty", exp_q.size(), 0);

        // Backpressure: data changes while the hold register is full.
        send(8'h3C, a0);
        send(8'h96, a1);
        in_data = 8'h11;
        #1 check("bp_ready_low0", in_ready, 0);
        @(posedge clk);
        #1 in_data = 8'h22;
        check("bp_ready_low1", in_ready, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        idle_cycles(20);
        check("bp_q_empty", exp_q.size(), 0);

        // Reset mid-word with a second word held.
        send(8'hB4, a0);
        send(8'h5A, a1);
        in_valid = 1'b0;
        idle_cycles(1);
        idle_cycles(1);
        #2 rst = 1'b1;
        #1;
        check("midrst_w", w, IDLE);
        check("midrst_w_valid", w_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_busy", busy, 0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check("midrst_release_ready", in_ready, 1);
        idle_cycles(20);
        check("midrst_busy_after", busy, 0);

        // Recovery after reset.
        send(8'h69, a0);
        in_valid = 1'b0;
        idle_cycles(12);
        check("final_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/w_serializer.md
# w_serializer

Parallel-to-serial source for the sequence-detector top. It accepts WIDTH-bit words on a valid/ready handshake and shifts them out one bit per clock on `w`, which feeds the Moore/Mealy detector pair's `w` input directly. A one-word holding register lets words stream gaplessly, so the detectors see contiguous patterns across word boundaries. When no word is in flight, `w` rests at a fixed idle level.

## Interface
- `WIDTH`, default 8: bits per word; legal range is 2..32.
- `IDLE_LEVEL`, default 1'b0: value driven on `w` when no bit is being shifted.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  upstream word offered.
- `in_data`  in  WIDTH  word to serialize.
- `in_ready`  out  1  block can take a word this cycle.
- `w`  out  1  serial bit to the detectors.
- `w_valid`  out  1  `w` carries a data bit this cycle.
- `word_done`  out  1  current `w` bit is the last bit of its word.
- `busy`  out  1  shifter active, or hold register occupied.

## Operation
- State:
  - shift register `sr` (WIDTH).
  - bit counter `cnt` (0..WIDTH-1).
  - flag `active`.
  - hold register `hr` (WIDTH).
  - flag `hold_full`.
- `in_ready = ~rst & ~hold_full`. An accept happens on an edge where `in_valid & in_ready`.
- `shifter_free` is true when `!active`, or when `active && cnt == WIDTH-1` (last bit is being shifted this cycle).
- Load rules, evaluated each edge in priority order:
  1. `shifter_free && hold_full`: load `sr <= hr` and clear `hold_full`, with `active=1` and `cnt=0`. Because `in_ready=0` in this case, no accept can coincide.
  2. `shifter_free && !hold_full && accept`: load `sr <= in_data` directly, with `active=1` and `cnt=0`.
  3. Otherwise, if accept: `hr <= in_data` and `hold_full=1`.
  4. `active && !shifter_free`: shift `sr` and increment `cnt`.
  5. `shifter_free` with nothing to load: `active=0`.
- Outputs are decoded from registers only, with no combinational path from `in_valid`/`in_data`:
  - `w = active ? sr[MSB] : IDLE_LEVEL` (bit order is set by the Configuration macro).
  - `w_valid = active`.
  - `word_done = active && cnt == WIDTH-1`.
  - `busy = active | hold_full`.
- `in_data` is sampled only on the accept edge. Upstream may change it afterwards.
- `in_valid` without `in_ready` is ignored. No bit is dropped and no word is duplicated.

## Timing
- Reset values, forced immediately and asynchronously and held while `rst=1`:
  - outputs: `w=IDLE_LEVEL`, `w_valid=0`, `word_done=0`, `busy=0`, `in_ready=0`.
  - state: `active=0`, `hold_full=0`, `cnt=0`.
  - `in_ready` rises in the first cycle after `rst` falls.
- Latency: a word accepted at edge k presents bit 0 on `w` during the cycle after edge k. Bit i appears after edge k+i. `word_done` is high after edge k+WIDTH-1.
- Throughput: one bit per clock. Back-to-back words produce a continuous `w_valid` with no bubble.
- Typical streaming sequence:
  - idle accept at edge 0 goes straight to the shifter;
  - the second word at edge 1 goes to hold, and `in_ready` drops;
  - at edge WIDTH the hold loads into the shifter and `in_ready` returns high.
- Reset mid-word: the partial word and the held word are discarded, and `w` returns to `IDLE_LEVEL` at once. The detectors are reset by the same `rst`.
- `in_valid` may be held high continuously. The block takes exactly one word per WIDTH cycles in steady state.

## Configuration
- `W_SERIALIZER_LSB_FIRST_EN`:
  - Defined: bits leave LSB first. `w = sr[0]` and `sr` shifts right.
  - Undefined (default): bits leave MSB first. `w = sr[WIDTH-1]` and `sr` shifts left.
  - Handshake and timing are identical in both modes.

## Test plan
- Reset with `IDLE_LEVEL=1`: assert `rst` mid-cycle. Required immediately, without waiting for a clock edge: `w=1`, `w_valid=0`, `in_ready=0`. After release, `in_ready=1` next cycle, and `w` stays 1 while no word is offered.
- Single word, MSB-first, WIDTH=8: accept 0xB4 at edge 0.
  - `w` = 1,0,1,1,0,1,0,0 after edges 0..7, with `w_valid=1` throughout.
  - `word_done` is high only after edge 7.
  - `w=IDLE_LEVEL` after edge 8.
- Back-to-back: hold `in_valid=1` with words 0xFF, 0x00, 0xA5.
  - 24 contiguous `w_valid` cycles with the correct bit sequence.
  - `in_ready` is low from edge 1 to edge 8 and from edge 9 to edge 16.
  - The third word is accepted at edge 9.
- Backpressure: with `hold_full=1`, change `in_data` while `in_valid=1`. The changed value is never serialized, and the held word is emitted intact.
- Reset mid-word: assert `rst` after bit 3 of 0xB4 with a second word held. `w` drops to idle at once, and neither word appears after release.
- With `W_SERIALIZER_LSB_FIRST_EN` defined: 0xB4 produces `w` = 0,0,1,0,1,1,0,1. Latency is unchanged.
